// File: rtl/elau_arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and derived widths.
package elau_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Quotient width that makes Q*Y+R the exact inverse of the floor divider.
  function automatic int width_q(input int width_x, input int width_y);
    return width_x - width_y + 1;
  endfunction

  // Bit-counter width able to index every quotient bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_add_iter_if.sv
// Operand/result handshake bundle for mul_add_iter.
// Signal suffixes are from the point of view of the computing block.
interface mul_add_iter_if #(
  parameter int widthX = 16,
  parameter int widthY = 8
);
  import elau_arith_pkg::*;

  localparam int widthQ = width_q(widthX, widthY);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [widthQ-1:0] Q_i;
  logic [widthY-1:0] Y_i;
  logic [widthY-1:0] R_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [widthX-1:0] X_o;
  logic              ovf_o;

  modport master (
    output in_valid_i, Q_i, Y_i, R_i, out_ready_i,
    input  in_ready_o, out_valid_o, X_o, ovf_o
  );

  modport slave (
    input  in_valid_i, Q_i, Y_i, R_i, out_ready_i,
    output in_ready_o, out_valid_o, X_o, ovf_o
  );

endinterface

// File: rtl/FullAdder.sv
// One-bit full adder cell used to build ripple-carry rows.
module FullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mul_add_iter.sv
// Iterative shift-and-add evaluator of X = Q*Y + R, one quotient bit per cycle.
// Inverse of the floor divider: signed Q and Y, unsigned R, exact result kept
// in widthX+2 bits so overflow of the widthX-bit output can be flagged.
module mul_add_iter
  import elau_arith_pkg::*;
#(
  parameter int widthX = 16,
  parameter int widthY = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  mul_add_iter_if.slave bus
);

  localparam int widthQ = width_q(widthX, widthY);
  localparam int widthA = widthX + 2;
  localparam int widthC = cnt_width(widthQ);
  localparam logic [widthC-1:0] LastCnt = widthC'(widthQ - 1);

  state_e            state_q, state_d;
  logic [widthA-1:0] acc_q, acc_d;
  logic [widthA-1:0] ysh_q, ysh_d;
  logic [widthQ-1:0] q_q, q_d;
  logic [widthC-1:0] cnt_q, cnt_d;

  logic              accept;
  logic              last_bit;
  logic              add_en;
  logic              sub_en;
  logic [widthA-1:0] add_b;
  logic [widthA-1:0] add_sum;
  logic [widthA:0]   carry;
  logic              unused_cout;
  logic [2:0]        acc_top;
  logic              ovf_exact;

  assign accept   = (state_q == IDLE) && bus.in_valid_i;
  assign last_bit = (cnt_q == LastCnt);

  // The quotient MSB carries negative weight, so its partial product is subtracted.
  assign add_en = q_q[0];
  assign sub_en = add_en & last_bit;
  assign add_b  = add_en ? (sub_en ? ~ysh_q : ysh_q) : '0;

  // Single ripple-carry row shared by every iteration; subtract = invert + carry-in.
  assign carry[0] = sub_en;
  for (genvar i = 0; i < widthA; i++) begin : g_row
    FullAdder u_fa (
      .a_i (acc_q[i]),
      .b_i (add_b[i]),
      .c_i (carry[i]),
      .s_o (add_sum[i]),
      .c_o (carry[i+1])
    );
  end
  // The carry out of a two's-complement row of this width carries no information.
  assign unused_cout = carry[widthA];

  // Exact result fits widthX signed bits only if its top three bits agree.
  assign acc_top   = acc_q[widthA-1:widthX-1];
  assign ovf_exact = !((&acc_top) || !(|acc_top));

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed widthQ-cycle CALC, DONE held until consumed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and a latch is never inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_bit) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and result outputs; result lines are forced to zero unless valid.
  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.X_o         = '0;
    bus.ovf_o       = 1'b0;
    unique case (state_q)
      IDLE: bus.in_ready_o = 1'b1;
      DONE: begin
        bus.out_valid_o = 1'b1;
        bus.X_o         = acc_q[widthX-1:0];
        bus.ovf_o       = ovf_exact;
      end
      default: ;
    endcase
  end

  // Datapath next-state: operand capture in IDLE, one quotient bit per CALC cycle.
  always_comb begin
    acc_d = acc_q;
    ysh_d = ysh_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = {{(widthA - widthY){1'b0}}, bus.R_i};
          ysh_d = {{(widthA - widthY){bus.Y_i[widthY-1]}}, bus.Y_i};
          q_d   = bus.Q_i;
          cnt_d = '0;
        end
      end
      CALC: begin
        acc_d = add_sum;
        ysh_d = ysh_q << 1;
        q_d   = q_q >> 1;
        cnt_d = last_bit ? '0 : cnt_q + widthC'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ysh_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ysh_q <= ysh_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_add_iter.sv
// Scoreboard bench for mul_add_iter: stimulus pushes expected results,
// an independent monitor pops and compares on every accepted output.
module tb_mul_add_iter;

  localparam int  WX = 16;
  localparam int  WY = 8;
  localparam int  WQ = WX - WY + 1;
  localparam time T  = 10;

  typedef struct {
    logic [WX-1:0] x;
    logic          ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #(T/2) clk = ~clk;

  mul_add_iter_if #(.widthX(WX), .widthY(WY)) bus ();

  mul_add_iter #(.widthX(WX), .widthY(WY)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then truncate and range-test.
  function automatic exp_t model(input int q, input int y, input int r);
    exp_t   e;
    longint ex;
    longint lim;
    ex    = longint'(q) * longint'(y) + longint'(r);
    lim   = longint'(1) <<< (WX - 1);
    e.x   = ex[WX-1:0];
    e.ovf = (ex < -lim) || (ex > lim - 1);
    return e;
  endfunction

  function automatic int floor_div(input int x, input int y);
    int q;
    q = x / y;
    if ((x % y != 0) && ((x < 0) != (y < 0))) q = q - 1;
    return q;
  endfunction

  // Monitor: compare on every handshake, and require zeroed result lines otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result X_o=%0h with empty scoreboard at %0t", bus.X_o, $time);
        end else begin
          e = sb.pop_front();
          check("X_o", 32'(bus.X_o), 32'(e.x));
          check("ovf_o", 32'(bus.ovf_o), 32'(e.ovf));
        end
      end else if (bus.out_valid_o !== 1'b1) begin
        check("idle_result_zero", 32'({bus.ovf_o, bus.X_o}), 32'd0);
      end
    end
  end

  // Issue one operation, check latency/busy behaviour and optional output stall.
  task automatic do_op(input int q, input int y, input int r, input int hold, output time t_acc);
    int            n;
    bit            seen;
    logic [WX-1:0] x0;
    t_acc = 0;
    @(posedge clk); #1;
    n = 0;
    while (bus.in_ready_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(n < 50), 32'd1);
    bus.Q_i         = q[WQ-1:0];
    bus.Y_i         = y[WY-1:0];
    bus.R_i         = r[WY-1:0];
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = (hold == 0);
    @(posedge clk);
    t_acc = $time;
    #1;
    // Garbage offered while busy must be ignored.
    bus.Q_i = WQ'($urandom);
    bus.Y_i = WY'($urandom);
    bus.R_i = WY'($urandom);
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o === 1'b1) begin
        check("latency", 32'(i), 32'(WQ));
        seen = 1'b1;
        break;
      end
      check("busy_in_ready", 32'(bus.in_ready_o), 32'd0);
    end
    bus.in_valid_i = 1'b0;
    check("out_valid_timeout", 32'(seen), 32'd1);
    if (seen && hold > 0) begin
      x0 = bus.X_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_out_valid", 32'(bus.out_valid_o), 32'd1);
        check("hold_X_stable", 32'(bus.X_o), 32'(x0));
        check("hold_in_ready", 32'(bus.in_ready_o), 32'd0);
      end
      bus.out_ready_i = 1'b1;
      @(posedge clk); #1;
      check("idle_after_ready", 32'(bus.in_ready_o), 32'd1);
      check("valid_drop_after_ready", 32'(bus.out_valid_o), 32'd0);
    end
  endtask

  task automatic run(input int q, input int y, input int r, input int hold);
    time t;
    sb.push_back(model(q, y, r));
    do_op(q, y, r, hold, t);
  endtask

  initial begin
    time  t1, t2;
    exp_t e;
    int   x, y, q, r, tries;

    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.Q_i         = 9'd5;
    bus.Y_i         = 8'd3;
    bus.R_i         = 8'd1;

    // Reset state, with in_valid asserted throughout reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_X_o", 32'(bus.X_o), 32'd0);
    check("rst_ovf_o", 32'(bus.ovf_o), 32'd0);
    bus.in_valid_i = 1'b0;
    rst_n          = 1'b1;
    mon_en         = 1'b1;

    // Directed vectors, including the overflow corner.
    run(5, -3, 2, 0);
    run(255, 127, 127, 0);
    run(-256, -128, 0, 0);
    run(-256, -128, 255, 0);
    run(0, -77, 200, 0);
    run(100, 0, 255, 0);
    run(-1, -1, 255, 0);
    run(-256, 127, 0, 0);

    // Output stall: result held while out_ready is low.
    run(3, 4, 1, 5);

    // Back-to-back throughput with out_ready held high.
    sb.push_back(model(17, -9, 44));
    do_op(17, -9, 44, 0, t1);
    sb.push_back(model(-33, 21, 7));
    do_op(-33, 21, 7, 0, t2);
    check("throughput", 32'((t2 - t1) / T), 32'(WQ + 2));

    // Reset in CALC cycle 4 aborts the operation; in_valid during reset ignored.
    @(posedge clk); #1;
    bus.Q_i        = 9'd7;
    bus.Y_i        = 8'd5;
    bus.R_i        = 8'd3;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("abort_X_o", 32'(bus.X_o), 32'd0);
    rst_n          = 1'b1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(bus.in_ready_o), 32'd1);
    repeat (2 * WQ) @(posedge clk);
    run(1, 1, 0, 0);

    // Random operands against the exact-arithmetic model.
    for (int k = 0; k < 20; k++) begin
      q = int'($urandom_range(0, (1 << WQ) - 1)) - (1 << (WQ - 1));
      y = int'($urandom_range(0, (1 << WY) - 1)) - (1 << (WY - 1));
      r = int'($urandom_range(0, (1 << WY) - 1));
      run(q, y, r, int'($urandom_range(0, 2)));
    end

    // Round trip through a floor divide with a normalized positive divisor.
    for (int k = 0; k < 15; k++) begin
      tries = 0;
      do begin
        x = int'($urandom_range(0, (1 << WX) - 1)) - (1 << (WX - 1));
        y = int'($urandom_range(1 << (WY - 2), (1 << (WY - 1)) - 1));
        q = floor_div(x, y);
        tries++;
      end while ((q < -(1 << (WQ - 1)) || q > (1 << (WQ - 1)) - 1) && tries < 200);
      r     = x - q * y;
      e.x   = x[WX-1:0];
      e.ovf = 1'b0;
      sb.push_back(e);
      do_op(q, y, r, 0, t1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(T * 20000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_add_iter.md
MUL_ADD_ITER -- requirements
Module: mul_add_iter

Interface
REQ-001 Parameter widthX, default 16: word width of result X.
REQ-002 Parameter widthY, default 8: word width of Y and R; widthQ = widthX-widthY+1 is derived, not overridable.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  operands valid.
REQ-006 in_ready_o  output  1  block can accept operands.
REQ-007 Q_i  input  widthQ  quotient operand, two's complement signed.
REQ-008 Y_i  input  widthY  divisor operand, two's complement signed.
REQ-009 R_i  input  widthY  remainder operand, unsigned.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer accepts result.
REQ-012 X_o  output  widthX  result Q*Y+R, two's complement, truncated to widthX bits.
REQ-013 ovf_o  output  1  exact Q*Y+R not representable in widthX signed bits.

Function
REQ-014 Block SHALL compute X = Q*Y + R, the inverse of the team's floor divider; exact value held internally in widthX+2 signed bits.
REQ-015 FSM SHALL have states IDLE, CALC, DONE.
REQ-016 IDLE: in_ready_o=1; on in_valid_i=1 SHALL capture Q_i, Y_i, R_i, init accumulator to zero-extended R, set bit counter to 0, go CALC.
REQ-017 CALC: exactly one Q bit per cycle, LSB first; bits 0..widthQ-2 add Y<<i when set; bit widthQ-1 (negative weight) subtracts Y<<(widthQ-1) when set.
REQ-018 CALC SHALL last exactly widthQ cycles, then go DONE; out_valid_o rises exactly widthQ cycles after the accepting edge (9 cycles at defaults).
REQ-019 DONE: out_valid_o=1, X_o and ovf_o stable; stay in DONE while out_ready_i=0; on out_ready_i=1 go IDLE.
REQ-020 in_ready_o SHALL be 0 in CALC and DONE; inputs then ignored; no overlap of operations.
REQ-021 X_o SHALL equal the low widthX bits of the exact result; ovf_o=1 iff exact result outside [-2^(widthX-1), 2^(widthX-1)-1].
REQ-022 X_o and ovf_o SHALL be 0 whenever out_valid_o=0.
REQ-023 Q=0 or Y=0 SHALL still take widthQ CALC cycles (fixed latency, no early exit).
REQ-024 Sustained throughput: one result per widthQ+2 cycles when out_ready_i held 1.

Reset
REQ-025 rst_ni=0 at a rising edge SHALL force IDLE, in_ready_o=1, out_valid_o=0, X_o=0, ovf_o=0, counter and accumulator 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation; no result ever produced for it.
REQ-027 in_valid_i while rst_ni=0 SHALL be ignored.

Structure
REQ-028 Shared package elau_arith_pkg SHALL hold the FSM state enum and a widthQ derivation function.
REQ-029 Per-cycle add/subtract SHALL be one widthX+2-bit ripple-carry row built from the codebase FullAdder cell, subtract by inverted operand and carry-in 1.
REQ-030 No other sub-modules; one shared adder row for all cycles.

Verification (defaults 16/8)
REQ-031 Q=5, Y=-3, R=2 -> after 9 cycles X_o=0xFFF3 (-13), ovf_o=0.
REQ-032 Q=255, Y=127, R=127 -> X_o=0x7F00 (32512), ovf_o=0.
REQ-033 Q=-256, Y=-128, R=0 -> X_o=0x8000, ovf_o=1.
REQ-034 Q=3, Y=4, R=1, out_ready_i=0 for 5 cycles -> out_valid_o and X_o=0x000D held stable, in_ready_o=0; IDLE one cycle after out_ready_i=1.
REQ-035 rst_ni=0 at CALC cycle 4 -> next cycle IDLE, out_valid_o=0; fresh op Q=1, Y=1, R=0 gives X_o=0x0001 on schedule.
REQ-036 Random round-trip: signed floor divide of random X by random normalized Y, feed Q, Y, R -> X_o equals original X, ovf_o=0.
